deassign_ctrl: RTL

Register-override controller modelling procedural `assign`/`deassign` semantics in synthesizable form. A normal load path writes a WIDTH-bit register. A pin request overrides ("assigns") it with a constant, and a release request ("deassigns") hands control back. The register keeps the pinned value until the next normal load. Used as the release-side counterpart to the procedural-assign tests: bench stimulus pins a value, then checks release behaviour and lost-write accounting.

---
 rtl/deassign_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/deassign_ctrl.sv
// deassign_ctrl: register with a normal load path plus a pin/release override
// that mimics procedural assign/deassign. Release keeps the pinned value until
// the next normal load. All outputs are registered.
// Optional auto-release after TIMEOUT edges in PINNED: define DEASSIGN_CTRL_TIMEOUT_EN.
module deassign_ctrl #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             pin_req,
  input  logic [WIDTH-1:0] pin_data,
  input  logic             rel_req,
  output logic [WIDTH-1:0] value,
  output logic             pinned,
  output logic             pin_ack,
  output logic             rel_ack,
  output logic             load_lost,
  output logic [7:0]       pin_cycles,
  output logic             timed_out
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PINNED  = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  // Out-of-range TIMEOUT values have no legal meaning; this block only gives
  // the parameter a visible home in builds that leave auto-release off.
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
  end

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             pinned_q, pinned_d;
  logic             pin_ack_q, pin_ack_d;
  logic             rel_ack_q, rel_ack_d;
  logic             load_lost_q, load_lost_d;
  logic [7:0]       pin_cycles_q, pin_cycles_d;
  logic             timed_out_q, timed_out_d;
  logic             to_hit;

`ifdef DEASSIGN_CTRL_TIMEOUT_EN
  // Count reaching TIMEOUT-1 at an edge means this edge is the TIMEOUT-th one.
  assign to_hit = (pin_cycles_q == 8'(TIMEOUT - 1));
`else
  assign to_hit = 1'b0;
`endif

  // Next-state and registered-output decode.
  always_comb begin
    state_d      = state_q;
    value_d      = value_q;
    pinned_d     = 1'b0;
    pin_ack_d    = 1'b0;
    rel_ack_d    = 1'b0;
    load_lost_d  = 1'b0;
    pin_cycles_d = pin_cycles_q;
    timed_out_d  = 1'b0;
    case (state_q)
      S_PINNED: begin
        // Loads are always discarded while pinned; count saturates at 255.
        load_lost_d  = load;
        pin_cycles_d = (pin_cycles_q == 8'hFF) ? 8'hFF : pin_cycles_q + 8'd1;
        if (rel_req) begin
          // Release beats a simultaneous re-pin.
          state_d   = S_RELEASE;
          rel_ack_d = 1'b1;
        end else if (pin_req) begin
          // Re-pin beats auto-release and restarts the count.
          value_d      = pin_data;
          pin_ack_d    = 1'b1;
          pinned_d     = 1'b1;
          pin_cycles_d = 8'd0;
        end else if (to_hit) begin
          state_d     = S_RELEASE;
          rel_ack_d   = 1'b1;
          timed_out_d = 1'b1;
        end else begin
          pinned_d = 1'b1;
        end
      end
      default: begin
        // IDLE and the one-cycle RELEASE state behave identically; rel_req is ignored.
        state_d = S_IDLE;
        if (pin_req) begin
          state_d      = S_PINNED;
          value_d      = pin_data;
          pin_ack_d    = 1'b1;
          pinned_d     = 1'b1;
          pin_cycles_d = 8'd0;
          load_lost_d  = load;
        end else if (load) begin
          value_d = load_data;
        end
      end
    endcase
  end

  // State and output registers, cleared immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      value_q      <= '0;
      pinned_q     <= 1'b0;
      pin_ack_q    <= 1'b0;
      rel_ack_q    <= 1'b0;
      load_lost_q  <= 1'b0;
      pin_cycles_q <= 8'd0;
      timed_out_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      value_q      <= value_d;
      pinned_q     <= pinned_d;
      pin_ack_q    <= pin_ack_d;
      rel_ack_q    <= rel_ack_d;
      load_lost_q  <= load_lost_d;
      pin_cycles_q <= pin_cycles_d;
      timed_out_q  <= timed_out_d;
    end
  end

  assign value      = value_q;
  assign pinned     = pinned_q;
  assign pin_ack    = pin_ack_q;
  assign rel_ack    = rel_ack_q;
  assign load_lost  = load_lost_q;
  assign pin_cycles = pin_cycles_q;
  assign timed_out  = timed_out_q;

endmodule
